// File: rtl/pa_ram_ctrl.sv
// PA RAM controller: streams 32-bit weight words into PA RAM and reads 128-bit vectors back out.
// Optional range checking is enabled by defining PA_RAM_CTRL_BOUND_CHECK_EN.
module pa_ram_ctrl #(
  parameter int ADDR_WIDTH    = 13,
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_load,
  input  logic [13:0]                         load_words,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [31:0]                         s_data,
  input  logic                                start_read,
  input  logic [10:0]                         rd_base,
  input  logic [11:0]                         rd_len,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH*CHANNEL_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic                                ram_we,
  output logic [31:0]                         ram_wdata,
  input  logic [DATA_WIDTH*CHANNEL_WIDTH-1:0] ram_rdata,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_ADDR, RD_DATA, RD_HOLD} state_t;

  state_t      state, next_state;
  logic [13:0] wr_cnt, words_q;
  logic [10:0] rd_ptr;
  logic [11:0] rd_left;
  logic        ld_bad, rd_bad, err_set;
  logic        beat, accept, fin;

`ifdef PA_RAM_CTRL_BOUND_CHECK_EN
  assign ld_bad  = (load_words == '0) || (load_words > 14'd8192);
  assign rd_bad  = (rd_len == '0) || (({2'b00, rd_base} + {1'b0, rd_len}) > 13'd2048);
  assign err_set = (state == IDLE) && (start_load ? ld_bad : (start_read && rd_bad));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`else
  assign ld_bad  = 1'b0;
  assign rd_bad  = 1'b0;
  assign err_set = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    beat       = 1'b0;
    accept     = 1'b0;
    fin        = 1'b0;
    case (state)
      IDLE: begin
        // Zero-length requests complete in place without touching the RAM.
        if (start_load) begin
          if (!ld_bad) begin
            if (load_words == '0) fin = 1'b1;
            else                  next_state = LOAD;
          end
        end else if (start_read && !rd_bad) begin
          if (rd_len == '0) fin = 1'b1;
          else              next_state = RD_ADDR;
        end
      end
      LOAD: begin
        s_ready   = 1'b1;
        ram_we    = s_valid;
        ram_addr  = ADDR_WIDTH'(wr_cnt);
        ram_wdata = s_data;
        if (s_valid) begin
          beat = 1'b1;
          if (wr_cnt == words_q - 14'd1) begin
            fin        = 1'b1;
            next_state = IDLE;
          end
        end
      end
      RD_ADDR: begin
        ram_addr   = ADDR_WIDTH'(rd_ptr);
        next_state = RD_DATA;
      end
      RD_DATA: begin
        ram_addr   = ADDR_WIDTH'(rd_ptr);
        next_state = RD_HOLD;
      end
      RD_HOLD: begin
        ram_addr = ADDR_WIDTH'(rd_ptr);
        if (m_ready) begin
          accept = 1'b1;
          if (rd_left == 12'd1) begin
            fin        = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = RD_ADDR;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      words_q <= '0;
      rd_ptr  <= '0;
      rd_left <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && start_load) begin
        wr_cnt  <= '0;
        words_q <= load_words;
      end else if (beat) begin
        wr_cnt <= wr_cnt + 14'd1;
      end
      if (state == IDLE && !start_load && start_read) begin
        rd_ptr  <= rd_base;
        rd_left <= rd_len;
      end else if (accept) begin
        rd_ptr  <= rd_ptr + 11'd1;
        rd_left <= rd_left - 12'd1;
      end
      if (state == RD_DATA) begin
        m_data  <= ram_rdata;
        m_valid <= 1'b1;
      end else if (accept) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pa_ram_ctrl.md
PA_RAM_CTRL -- requirements
Module: pa_ram_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 13, PA RAM address width; DATA_WIDTH, default 8, lane width; CHANNEL_WIDTH, default 16, lanes per read vector.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-high):
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start_load  in  1  one-cycle request to begin a weight load
load_words  in  14  number of 32-bit words to load, sampled at start_load
s_valid  in  1  load stream word valid
s_ready  out  1  load stream ready
s_data  in  32  load stream word
start_read  in  1  one-cycle request to begin a read burst
rd_base  in  11  first vector index, sampled at start_read
rd_len  in  12  vectors to read, sampled at start_read
m_valid  out  1  output vector valid
m_ready  in  1  output vector accepted
m_data  out  128  output vector, lane i = bits 8i+7:8i
ram_addr  out  13  to PA RAM addr
ram_we  out  1  to PA RAM we
ram_wdata  out  32  to PA RAM data_in
ram_rdata  in  128  from PA RAM data_out
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky range error (see Configuration)

Function
REQ-003 SHALL implement states IDLE, LOAD, RD_ADDR, RD_DATA, RD_HOLD.
REQ-004 IDLE: start_load -> LOAD, wr_cnt=0; else start_read -> RD_ADDR, rd_ptr=rd_base, rd_left=rd_len; start_load wins when both high; starts outside IDLE SHALL be ignored.
REQ-005 LOAD: s_ready=1; ram_we=s_valid, ram_addr=wr_cnt[12:0], ram_wdata=s_data, all combinational same cycle; wr_cnt increments on each s_valid&&s_ready beat.
REQ-006 LOAD: beat with wr_cnt==load_words-1 SHALL be last write; next state IDLE, done=1 for one cycle.
REQ-007 Word address mapping: bits 12:9 select bank 0..15, bits 8:0 word within bank; word n lands in bank n>>9.
REQ-008 RD_ADDR: ram_addr={2'b00,rd_ptr}, ram_we=0; next RD_DATA unconditionally.
REQ-009 RD_DATA: ram_addr held equal to RD_ADDR value; m_data<=ram_rdata registered; m_valid<=1; next RD_HOLD.
REQ-010 RD_HOLD: m_valid=1, m_data stable until m_ready; on m_ready: rd_ptr+1 (11-bit wrap 2047->0), rd_left-1; rd_left==1 -> IDLE with m_valid=0 and done=1, else RD_ADDR.
REQ-011 Read throughput SHALL be one vector per 3 cycles with m_ready held high; first m_valid 3 cycles after start_read.
REQ-012 ram_we SHALL be 0 in every state except LOAD; ram_addr=0, s_ready=0, m_valid=0 in IDLE.
REQ-013 load_words==0 or rd_len==0 (check disabled): operation completes immediately, next cycle IDLE with done=1, no RAM access.

Reset
REQ-014 rst high SHALL asynchronously force IDLE, s_ready=0, m_valid=0, m_data=0, ram_we=0, ram_addr=0, done=0, err=0, busy=0, counters 0.
REQ-015 Reset mid-LOAD or mid-read SHALL abort with no further RAM write and no done pulse.

Configuration
REQ-016 Macro PA_RAM_CTRL_BOUND_CHECK_EN defined: start_load with load_words==0 or >8192, or start_read with rd_len==0 or rd_base+rd_len>2048, SHALL set err=1 (sticky until rst), stay IDLE, no done.
REQ-017 Macro undefined: no check, err tied 0, counters wrap modulo width, zero length per REQ-013.

Verification
REQ-018 Load 4 words 0x04030201..0x100F0E0D, s_valid high -> ram_we 4 consecutive cycles, ram_addr 0..3, done 1 cycle after last beat.
REQ-019 Load 513 words with s_valid toggling every cycle -> writes only on valid beats, word 512 at ram_addr 0x0200 (bank 1), s_ready low after done.
REQ-020 Read rd_base=5, rd_len=3, m_ready high -> ram_addr 5,6,7, m_data equals ram_rdata sampled in RD_DATA, m_valid every third cycle, done with last accept.
REQ-021 Read rd_len=2, m_ready low 10 cycles -> m_valid and m_data held stable, ram_addr unchanged, no advance.
REQ-022 start_load and start_read same cycle -> LOAD entered, read ignored; rst asserted mid-read -> m_valid 0 immediately, no done.
REQ-023 With PA_RAM_CTRL_BOUND_CHECK_EN: rd_base=2040, rd_len=16 -> err=1, busy=0; without: read wraps ram_addr 2047->0.
